lru_req_agent: RTL and testbench

Requester-side front end for the LRU matrix arbiter. It collects burst requests from `NUM_REQ` clients and drives the arbiter's `req` vector. It consumes the arbiter's combinational one-hot `gnt`, then runs the granted client's burst on a single shared downstream bus. It also monitors per-client wait time for starvation and flags arbiter protocol violations.

---
 rtl/lru_pkg.sv | 32 +++
 rtl/lru_starve_cnt.sv | 35 +++
 rtl/lru_req_agent.sv | 114 +++++++++++
 tb/tb_lru_req_agent.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared types and helpers for the LRU requester agent
package lru_pkg;

   // Client count shared with the matrix arbiter; the agent's NUM_REQ must match.
   localparam int LRU_NUM_REQ = 10;
   localparam int OWN_W       = $clog2(LRU_NUM_REQ);

   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } lru_agent_st_e;

   function automatic logic [OWN_W-1:0] onehot_to_idx(input logic [LRU_NUM_REQ-1:0] vec);
      logic [OWN_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < LRU_NUM_REQ; i++) begin
         if (vec[i]) begin
            idx = idx | OWN_W'(i);
         end
      end
      return idx;
   endfunction

   // A grant is usable only if it is one-hot and names a client that is asking.
   function automatic logic gnt_is_legal(input logic [LRU_NUM_REQ-1:0] gnt,
                                         input logic [LRU_NUM_REQ-1:0] valid);
      logic onehot;
      onehot = (gnt != '0) && ((gnt & (gnt - LRU_NUM_REQ'(1))) == '0);
      return onehot && ((gnt & ~valid) == '0);
   endfunction

endpackage

// File: rtl/lru_starve_cnt.sv
// rtl/lru_starve_cnt.sv - per-client saturating wait counter with starvation flag
module lru_starve_cnt #(
   parameter int STARVE_W     = 8,
   parameter int STARVE_LIMIT = 200
) (
   input  logic clk,
   input  logic rst_b,
   input  logic wait_i,
   output logic starve_o
);

   localparam logic [STARVE_W-1:0] CNT_MAX = '1;
   localparam logic [STARVE_W-1:0] LIMIT   = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] cnt_q;
   logic [STARVE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (wait_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/lru_req_agent.sv
// rtl/lru_req_agent.sv - requester front end for the LRU matrix arbiter
// Presents client requests to the arbiter, then runs one granted burst at a time.
module lru_req_agent
   import lru_pkg::*;
#(
   parameter int NUM_REQ      = LRU_NUM_REQ,
   parameter int LEN_W        = 4,
   parameter int STARVE_W     = 8,
   parameter int STARVE_LIMIT = 200
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic [NUM_REQ-1:0]       cli_valid_i,
   input  logic [NUM_REQ*LEN_W-1:0] cli_len_i,
   output logic [NUM_REQ-1:0]       cli_accept_o,
   output logic [NUM_REQ-1:0]       req_o,
   input  logic [NUM_REQ-1:0]       gnt_i,
   output logic                     bus_valid_o,
   output logic [OWN_W-1:0]         bus_owner_o,
   output logic [LEN_W-1:0]         bus_beat_o,
   output logic                     bus_last_o,
   input  logic                     bus_ready_i,
   output logic [NUM_REQ-1:0]       starve_o,
   output logic                     err_o,
   output logic                     idle_o
);

   lru_agent_st_e    state_q;
   logic [OWN_W-1:0] owner_q;
   logic [LEN_W-1:0] beat_q;
   logic [LEN_W-1:0] beat_d;
   logic [LEN_W-1:0] len_q;
   logic             bus_valid_q;
   logic             bus_last_q;
   logic             err_q;

   logic             in_arb;
   logic             gnt_legal;
   logic             gnt_illegal;
   logic [OWN_W-1:0] gnt_idx;
   logic [LEN_W-1:0] gnt_len;

   assign in_arb      = (state_q == ARB);
   assign gnt_legal   = in_arb && gnt_is_legal(gnt_i, cli_valid_i);
   assign gnt_illegal = in_arb && (gnt_i != '0) && !gnt_legal;
   assign gnt_idx     = onehot_to_idx(gnt_i);
   assign gnt_len     = cli_len_i[int'(gnt_idx)*LEN_W +: LEN_W];
   assign beat_d      = beat_q + LEN_W'(1);

   // Dropping req during a burst keeps the arbiter's LRU state frozen.
   assign req_o        = in_arb ? cli_valid_i : '0;
   assign cli_accept_o = (gnt_legal && rst_b) ? gnt_i : '0;
   assign idle_o       = in_arb && (cli_valid_i == '0);

   assign bus_valid_o = bus_valid_q;
   assign bus_owner_o = owner_q;
   assign bus_beat_o  = beat_q;
   assign bus_last_o  = bus_last_q;
   assign err_o       = err_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ARB;
         owner_q     <= '0;
         beat_q      <= '0;
         len_q       <= '0;
         bus_valid_q <= 1'b0;
         bus_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ARB: begin
               if (gnt_legal) begin
                  state_q     <= XFER;
                  owner_q     <= gnt_idx;
                  len_q       <= gnt_len;
                  beat_q      <= '0;
                  bus_valid_q <= 1'b1;
                  bus_last_q  <= (gnt_len == '0);
               end else if (gnt_illegal) begin
                  err_q <= 1'b1;
               end
            end
            XFER: begin
               if (bus_ready_i) begin
                  if (bus_last_q) begin
                     state_q     <= ARB;
                     bus_valid_q <= 1'b0;
                     bus_last_q  <= 1'b0;
                     beat_q      <= '0;
                  end else begin
                     beat_q     <= beat_d;
                     bus_last_q <= (beat_d == len_q);
                  end
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_starve
      lru_starve_cnt #(
         .STARVE_W    (STARVE_W),
         .STARVE_LIMIT(STARVE_LIMIT)
      ) u_starve_cnt (
         .clk     (clk),
         .rst_b   (rst_b),
         .wait_i  (cli_valid_i[i] & ~cli_accept_o[i]),
         .starve_o(starve_o[i])
      );
   end

endmodule

// File: tb/tb_lru_req_agent.sv
// tb/tb_lru_req_agent.sv - self-checking bench for lru_req_agent
module tb_lru_req_agent;

   localparam int N   = 10;
   localparam int LW  = 4;
   localparam int SW  = 8;
   localparam int LIM = 4;
   localparam int CMAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_b;
   logic [N-1:0]  cli_valid;
   logic [N*LW-1:0] cli_len;
   logic [N-1:0]  cli_accept;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          bus_valid;
   logic [3:0]    bus_owner;
   logic [LW-1:0] bus_beat;
   logic          bus_last;
   logic          bus_ready;
   logic [N-1:0]  starve;
   logic          err;
   logic          idle;

   // bench-side arbiter: 0 LRU, 1 no grant, 2 forced vector, 3 lowest index
   int           gmode;
   logic [N-1:0] gforce;
   int           order[N];

   // behavioural model
   bit           m_busy;
   int           m_owner, m_beat, m_len;
   int           m_cnt[N];
   bit           m_err;
   int           lens[N];
   logic [N-1:0] cur_acc, cur_gnt;
   int           dut_acc_cnt[N];
   int           dut_acc_total;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lru_req_agent #(
      .NUM_REQ(N), .LEN_W(LW), .STARVE_W(SW), .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .rst_b(rst_b),
      .cli_valid_i(cli_valid), .cli_len_i(cli_len), .cli_accept_o(cli_accept),
      .req_o(req), .gnt_i(gnt),
      .bus_valid_o(bus_valid), .bus_owner_o(bus_owner), .bus_beat_o(bus_beat),
      .bus_last_o(bus_last), .bus_ready_i(bus_ready),
      .starve_o(starve), .err_o(err), .idle_o(idle)
   );

   function automatic logic [N-1:0] arb_gnt(input logic [N-1:0] r, input int mode,
                                             input logic [N-1:0] f, input int ord[N]);
      logic [N-1:0] g;
      g = '0;
      if (r == '0 || mode == 1) return g;
      if (mode == 2) return f;
      for (int k = 0; k < N; k++) begin
         int idx = (mode == 3) ? k : ord[k];
         if (g == '0 && r[idx]) g[idx] = 1'b1;
      end
      return g;
   endfunction

   always_comb gnt = arb_gnt(req, gmode, gforce, order);

   function automatic bit legal(input logic [N-1:0] g, input logic [N-1:0] v);
      return ($countones(g) == 1) && ((g & ~v) == '0);
   endfunction

   function automatic int first_set(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [N-1:0] make_illegal(input logic [N-1:0] v);
      logic [N-1:0] f;
      int a, b;
      f = '0;
      if (v != '1 && $urandom_range(0, 1) == 1) begin
         do a = $urandom_range(0, N-1); while (v[a]);
         f[a] = 1'b1;
      end else begin
         a = $urandom_range(0, N-1);
         do b = $urandom_range(0, N-1); while (b == a);
         f[a] = 1'b1;
         f[b] = 1'b1;
      end
      return f;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_owner = 0; m_beat = 0; m_len = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic lru_touch(input int idx);
      int p;
      p = 0;
      for (int k = 0; k < N; k++) if (order[k] == idx) p = k;
      for (int k = p; k < N-1; k++) order[k] = order[k+1];
      order[N-1] = idx;
   endtask

   // Called once per cycle after inputs are driven: compare every output to the model.
   task automatic settle_check();
      logic [N-1:0] e_req, e_acc, e_starve;
      for (int i = 0; i < N; i++) cli_len[i*LW +: LW] = LW'(lens[i]);
      #1;
      e_req   = m_busy ? '0 : cli_valid;
      cur_gnt = arb_gnt(e_req, gmode, gforce, order);
      e_acc   = (!m_busy && legal(cur_gnt, cli_valid)) ? cur_gnt : '0;
      cur_acc = e_acc;
      for (int i = 0; i < N; i++) e_starve[i] = (m_cnt[i] >= LIM);
      chk("req", 64'(req), 64'(e_req));
      chk("cli_accept", 64'(cli_accept), 64'(e_acc));
      chk("bus_valid", 64'(bus_valid), 64'(m_busy));
      if (m_busy) begin
         chk("bus_owner", 64'(bus_owner), 64'(m_owner));
         chk("bus_beat", 64'(bus_beat), 64'(m_beat));
         chk("bus_last", 64'(bus_last), 64'(m_beat == m_len));
      end
      chk("starve", 64'(starve), 64'(e_starve));
      chk("err", 64'(err), 64'(m_err));
      chk("idle", 64'(idle), 64'(!m_busy && cli_valid == '0));
      for (int i = 0; i < N; i++) dut_acc_cnt[i] += int'(cli_accept[i]);
      dut_acc_total += $countones(cli_accept);
   endtask

   // Apply the clock edge to the model, then move to the next negedge.
   task automatic advance();
      int idx;
      idx = -1;
      for (int i = 0; i < N; i++) begin
         if (!cli_valid[i] || cur_acc[i]) m_cnt[i] = 0;
         else if (m_cnt[i] < CMAX) m_cnt[i]++;
      end
      if (!m_busy) begin
         if (cur_acc != '0) begin
            idx = first_set(cur_acc);
            m_busy = 1; m_owner = idx; m_len = lens[idx]; m_beat = 0;
         end else if (cur_gnt != '0) begin
            m_err = 1;
         end
      end else if (bus_ready) begin
         if (m_beat == m_len) m_busy = 0;
         else m_beat++;
      end
      @(negedge clk);
      if (idx >= 0) lru_touch(idx);
   endtask

   task automatic step_drop();
      settle_check();
      advance();
      cli_valid = cli_valid & ~cur_acc;
   endtask

   task automatic flush();
      int n;
      n = 0;
      gmode = 0;
      bus_ready = 1'b1;
      while ((m_busy || cli_valid != '0) && n < 80) begin
         step_drop();
         n++;
      end
      chk("flush_done", 64'(m_busy || cli_valid != '0), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_b = 1'b0; cli_valid = '0; bus_ready = 1'b1; gmode = 0; gforce = '0;
      dut_acc_total = 0;
      for (int i = 0; i < N; i++) begin order[i] = i; lens[i] = 0; dut_acc_cnt[i] = 0; end
      for (int i = 0; i < N; i++) cli_len[i*LW +: LW] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_bus_valid", 64'(bus_valid), 64'(0));
      chk("rst_idle", 64'(idle), 64'(1));
      chk("rst_owner", 64'(bus_owner), 64'(0));
      rst_b = 1'b1;
      settle_check();
      advance();

      // single client, three-beat burst
      cli_valid = 10'h008; lens[3] = 2;
      settle_check();
      chk("t1_accept", 64'(cli_accept), 64'(10'h008));
      chk("t1_bus_idle", 64'(bus_valid), 64'(0));
      advance();
      cli_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         settle_check();
         chk("t1_valid", 64'(bus_valid), 64'(1));
         chk("t1_owner", 64'(bus_owner), 64'(3));
         chk("t1_beat", 64'(bus_beat), 64'(c - 1));
         chk("t1_last", 64'(bus_last), 64'(c == 3));
         chk("t1_req0", 64'(req), 64'(0));
         advance();
      end
      settle_check();
      chk("t1_idle", 64'(idle), 64'(1));
      advance();

      // contention: every client always pending, single-beat bursts
      for (int i = 0; i < N; i++) begin dut_acc_cnt[i] = 0; lens[i] = 0; end
      dut_acc_total = 0;
      cli_valid = '1;
      for (int c = 0; c < 100 && dut_acc_total < 20; c++) begin
         settle_check();
         advance();
      end
      for (int i = 0; i < N; i++) chk("t2_fair", 64'(dut_acc_cnt[i]), 64'(2));
      cli_valid = '0;
      flush();

      // backpressure on beat 1
      cli_valid = 10'h040; lens[6] = 3;
      settle_check();
      chk("t3_accept", 64'(cli_accept), 64'(10'h040));
      advance();
      cli_valid = '0;
      settle_check();
      chk("t3_beat0", 64'(bus_beat), 64'(0));
      advance();
      bus_ready = 1'b0;
      repeat (5) begin
         settle_check();
         chk("t3_hold_beat", 64'(bus_beat), 64'(1));
         chk("t3_hold_owner", 64'(bus_owner), 64'(6));
         chk("t3_hold_valid", 64'(bus_valid), 64'(1));
         chk("t3_no_accept", 64'(cli_accept), 64'(0));
         advance();
      end
      bus_ready = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         settle_check();
         chk("t3_beat", 64'(bus_beat), 64'(b));
         chk("t3_last", 64'(bus_last), 64'(b == 3));
         advance();
      end
      settle_check();
      chk("t3_done", 64'(bus_valid), 64'(0));
      advance();

      // illegal multi-hot grant, then a legal one
      cli_valid = 10'h006; lens[1] = 0; lens[2] = 1;
      gmode = 2; gforce = 10'h006;
      settle_check();
      chk("t4_no_accept", 64'(cli_accept), 64'(0));
      advance();
      gmode = 0;
      settle_check();
      chk("t4_err", 64'(err), 64'(1));
      chk("t4_arb", 64'(bus_valid), 64'(0));
      chk("t4_accept_one", 64'($countones(cli_accept)), 64'(1));
      advance();
      cli_valid = cli_valid & ~cur_acc;
      flush();

      // starvation of client 9 behind fixed-priority grants to client 0
      gmode = 3; lens[0] = 0; lens[9] = 0;
      cli_valid = 10'h201;
      for (int c = 0; c <= 4; c++) begin
         settle_check();
         if (c == 3) chk("t5_not_yet", 64'(starve[9]), 64'(0));
         if (c == 4) chk("t5_starve", 64'(starve[9]), 64'(1));
         advance();
      end
      cli_valid[0] = 1'b0;
      begin
         bit seen;
         seen = 0;
         for (int c = 0; c < 10 && !seen; c++) begin
            settle_check();
            seen = cli_accept[9];
            advance();
            cli_valid = cli_valid & ~cur_acc;
         end
         chk("t5_accept9_seen", 64'(seen), 64'(1));
         settle_check();
         chk("t5_cleared", 64'(starve[9]), 64'(0));
         advance();
      end
      flush();

      // reset on beat 2 of an 8-beat burst
      cli_valid = 10'h020; lens[5] = 7;
      settle_check();
      advance();
      cli_valid = '0;
      for (int b = 0; b < 2; b++) begin settle_check(); advance(); end
      settle_check();
      chk("t6_beat2", 64'(bus_beat), 64'(2));
      cli_valid = 10'h080; lens[7] = 2;
      rst_b = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_valid", 64'(bus_valid), 64'(0));
      chk("t6_rst_last", 64'(bus_last), 64'(0));
      chk("t6_rst_beat", 64'(bus_beat), 64'(0));
      chk("t6_rst_owner", 64'(bus_owner), 64'(0));
      chk("t6_rst_err", 64'(err), 64'(0));
      chk("t6_rst_starve", 64'(starve), 64'(0));
      chk("t6_rst_accept", 64'(cli_accept), 64'(0));
      chk("t6_rst_req", 64'(req), 64'(10'h080));
      chk("t6_rst_idle", 64'(idle), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      settle_check();
      chk("t6_new_accept", 64'(cli_accept), 64'(10'h080));
      advance();
      cli_valid = '0;
      settle_check();
      chk("t6_new_beat", 64'(bus_beat), 64'(0));
      chk("t6_new_owner", 64'(bus_owner), 64'(7));
      advance();
      flush();

      // randomized traffic with mixed arbiter behaviour and backpressure
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = $urandom_range(0, 99);
         gmode = (r < 70) ? 0 : (r < 80) ? 1 : (r < 83) ? 2 : 3;
         if (gmode == 2) gforce = make_illegal(cli_valid);
         bus_ready = ($urandom_range(0, 3) != 0);
         settle_check();
         advance();
         for (int i = 0; i < N; i++) begin
            if (cur_acc[i]) begin
               cli_valid[i] = 1'b0;
            end else if (!cli_valid[i] && $urandom_range(0, 4) == 0) begin
               cli_valid[i] = 1'b1;
               lens[i] = $urandom_range(0, 7);
            end
         end
      end
      flush();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
